band_pot_scan: RTL and testbench

Autonomous scan controller for the A2D interface in the audio equalizer. It sequences conversions round-robin over the six slide-pot channels: five EQ band gains plus volume. Each 12-bit result is latched into a dedicated output register for the band-scaling datapath. It owns the `strt_cnv`/`chnnl` side of the A2D interface, so the A2D interface is never driven by more than one master.

---
 rtl/band_pot_scan.sv | 112 +++++++++++
 tb/tb_band_pot_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/band_pot_scan.sv
// Round-robin A2D scan over the five EQ band pots and the volume pot.
// Each completed conversion is latched into the output register of its slot.
//
// state | meaning
// IDLE  | scan paused, slot held
// START | one-cycle strt_cnv pulse for the current slot
// WAIT  | conversion in flight, capture on cnv_cmplt
// GAP   | idle spacing of GAP_CYCLES clocks before the next START
module band_pot_scan #(
    parameter int GAP_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        valid,
    output logic        sweep_done
);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    state_t        state;
    logic [2:0]    slot;
    logic [CW-1:0] gap_cnt;

    assign strt_cnv = (state == START);

    // chnnl depends on slot only, so it holds across both A2D SPI transactions
    always_comb begin
        chnnl = 3'd1;
        case (slot)
            3'd0:    chnnl = 3'd1;
            3'd1:    chnnl = 3'd0;
            3'd2:    chnnl = 3'd4;
            3'd3:    chnnl = 3'd2;
            3'd4:    chnnl = 3'd3;
            3'd5:    chnnl = 3'd7;
            default: chnnl = 3'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot       <= 3'd0;
            gap_cnt    <= '0;
            valid      <= 1'b0;
            sweep_done <= 1'b0;
            POT_LP     <= 12'h000;
            POT_B1     <= 12'h000;
            POT_B2     <= 12'h000;
            POT_B3     <= 12'h000;
            POT_HP     <= 12'h000;
            VOLUME     <= 12'h000;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) state <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnv_cmplt) begin
                        case (slot)
                            3'd0:    POT_LP <= res;
                            3'd1:    POT_B1 <= res;
                            3'd2:    POT_B2 <= res;
                            3'd3:    POT_B3 <= res;
                            3'd4:    POT_HP <= res;
                            3'd5:    VOLUME <= res;
                            default: ;
                        endcase
                        if (slot == 3'd5) begin
                            slot       <= 3'd0;
                            valid      <= 1'b1;
                            sweep_done <= 1'b1;
                        end else begin
                            slot <= slot + 3'd1;
                        end
                        gap_cnt <= '0;
                        state   <= en ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= START;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_band_pot_scan.sv
// Directed bench for band_pot_scan with a behavioural A2D model of fixed latency.
module tb_band_pot_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;
    logic        valid;
    logic        sweep_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sd_cnt = 0;

    bit          model_on = 0;
    int          lat = 3;
    int          lat_cnt = 0;
    bit          garble = 0;
    logic [11:0] pend_res = 12'h000;
    logic [11:0] xor_mask = 12'h000;

    band_pot_scan #(.GAP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cnv_cmplt(cnv_cmplt), .res(res),
        .strt_cnv(strt_cnv), .chnnl(chnnl),
        .POT_LP(POT_LP), .POT_B1(POT_B1), .POT_B2(POT_B2), .POT_B3(POT_B3),
        .POT_HP(POT_HP), .VOLUME(VOLUME), .valid(valid), .sweep_done(sweep_done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (sweep_done === 1'b1) sd_cnt++;

    // A2D model: result appears lat WAIT cycles after START; once captured,
    // res is corrupted while cnv_cmplt stays high so stale captures show up.
    always @(negedge clk) begin
        if (!rst_n) begin
            lat_cnt = 0;
            garble = 0;
            if (model_on) cnv_cmplt = 1'b0;
        end else if (model_on) begin
            if (garble) begin
                res = 12'hFFF;
                garble = 0;
            end
            if (strt_cnv) begin
                cnv_cmplt = 1'b0;
                lat_cnt = lat;
                pend_res = ({9'h0, chnnl} * 12'h111) ^ xor_mask;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    cnv_cmplt = 1'b1;
                    res = pend_res;
                    garble = 1;
                end
            end
        end
    end

    task automatic wait_strt(output bit ok, output logic [2:0] ch, output int t);
        ok = 0; ch = 3'd0; t = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (strt_cnv === 1'b1) begin
                ok = 1; ch = chnnl; t = cyc;
                return;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        int strt_seen;
        strt_seen = 0;
        rst_n = 0; en = 0; cnv_cmplt = 0; res = 12'h000;
        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (strt_cnv !== 1'b0) strt_seen++;
        end
        chk("reset_no_strt", strt_seen, 0);
        chk("reset_chnnl", chnnl, 3'd1);
        chk("reset_pots", {POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME}, 0);
        chk("reset_pots_hi", {POT_HP, VOLUME}, 0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_sweep_done", sweep_done, 1'b0);
    endtask

    task automatic test_stale_before_start();
        cnv_cmplt = 1'b1;
        res = 12'hABC;
        repeat (10) @(negedge clk);
        chk("stale_idle_lp", POT_LP, 12'h000);
        chk("stale_idle_strt", strt_cnv, 1'b0);
    endtask

    task automatic test_sweep();
        logic [2:0] exp_ch [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
        logic [2:0] ch;
        bit ok;
        int t, t_prev;
        bit got;
        lat = 3;
        sd_cnt = 0;
        model_on = 1;
        en = 1;
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            wait_strt(ok, ch, t);
            chk($sformatf("sweep_strt_found_%0d", i), ok, 1'b1);
            chk($sformatf("sweep_chnnl_%0d", i), ch, exp_ch[i]);
            if (i > 0) chk($sformatf("sweep_period_%0d", i), t - t_prev, 8);
            if (i == 5) chk("sweep_valid_before", valid, 1'b0);
            t_prev = t;
            @(negedge clk);
            chk($sformatf("sweep_strt_width_%0d", i), strt_cnv, 1'b0);
        end
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (sweep_done === 1'b1) got = 1;
            else @(negedge clk);
        end
        chk("sweep_done_seen", got, 1'b1);
        chk("sweep_lp", POT_LP, 12'h111);
        chk("sweep_b1", POT_B1, 12'h000);
        chk("sweep_b2", POT_B2, 12'h444);
        chk("sweep_b3", POT_B3, 12'h222);
        chk("sweep_hp", POT_HP, 12'h333);
        chk("sweep_volume", VOLUME, 12'h777);
        chk("sweep_valid", valid, 1'b1);
        @(negedge clk);
        chk("sweep_done_width", sweep_done, 1'b0);
        chk("sweep_done_count", sd_cnt, 1);
        @(negedge clk);
        chk("gap_stale_lp", POT_LP, 12'h111);
        chk("gap_stale_volume", VOLUME, 12'h777);
        chk("valid_sticky", valid, 1'b1);
    endtask

    task automatic test_period();
        logic [2:0] ch;
        bit ok_a, ok_b;
        int ta, tb;
        lat = 5;
        wait_strt(ok_a, ch, ta);
        wait_strt(ok_b, ch, tb);
        chk("period_found", {ok_a, ok_b}, 2'b11);
        chk("period_l5", tb - ta, 10);
    endtask

    task automatic test_drop_en();
        logic [2:0] ch;
        bit ok;
        int t, strt_seen, c;
        xor_mask = 12'h00F;
        ok = 0; ch = 3'd0;
        for (int i = 0; i < 8 && ch != 3'd4; i++) wait_strt(ok, ch, t);
        chk("drop_found_slot2", ch, 3'd4);
        @(negedge clk);
        en = 0;
        repeat (20) @(negedge clk);
        chk("drop_b2_captured", POT_B2, 12'h44B);
        strt_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (strt_cnv !== 1'b0) strt_seen++;
        end
        chk("drop_no_strt", strt_seen, 0);
        chk("drop_chnnl_held", chnnl, 3'd2);
        xor_mask = 12'h000;
        c = cyc;
        en = 1;
        wait_strt(ok, ch, t);
        chk("resume_chnnl", ch, 3'd2);
        chk("resume_latency", t - c, 1);
    endtask

    task automatic test_reset_mid();
        logic [2:0] ch;
        bit ok;
        int t;
        ok = 0; ch = 3'd0;
        for (int i = 0; i < 8 && ch != 3'd3; i++) wait_strt(ok, ch, t);
        chk("rstmid_found_slot4", ch, 3'd3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rstmid_chnnl", chnnl, 3'd1);
        chk("rstmid_pots", {POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME}, 0);
        chk("rstmid_valid", valid, 1'b0);
        chk("rstmid_strt", strt_cnv, 1'b0);
        chk("rstmid_sweep_done", sweep_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        en = 1;
        wait_strt(ok, ch, t);
        chk("rstmid_restart_found", ok, 1'b1);
        chk("rstmid_restart_chnnl", ch, 3'd1);
    endtask

    initial begin
        test_reset();
        test_stale_before_start();
        test_sweep();
        test_period();
        test_drop_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
